// File: rtl/cond_branch_unit.sv
// SPARC-style Bicc condition evaluation with icc register and delay-slot annul tracking.
// Optional ICC_BYPASS_EN: a branch issued with cc_we evaluates its condition on flags_in.
module cond_branch_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] flags_in,
    input  logic       cc_we,
    input  logic       valid,
    input  logic       stall,
    input  logic       is_branch,
    input  logic [3:0] cond,
    input  logic       annul_bit,
    output logic [3:0] icc,
    output logic       taken,
    output logic       annul
);
    typedef enum logic [1:0] {IDLE, SLOT_EXEC, SLOT_ANNUL} state_t;

    state_t     r_state, w_next;
    logic [3:0] r_icc;
    logic       r_taken;
    logic [3:0] w_flags;
    logic       w_accept;
    logic       w_cond;
    logic       w_z, w_n, w_c, w_v;

    assign annul    = (r_state == SLOT_ANNUL) & valid;
    assign w_accept = valid & ~stall & ~annul;

`ifdef ICC_BYPASS_EN
    assign w_flags = cc_we ? flags_in : r_icc;
`else
    assign w_flags = r_icc;
`endif

    assign {w_z, w_n, w_c, w_v} = w_flags;

    always_comb begin
        w_cond = 1'b0;
        case (cond)
            4'h0: w_cond = 1'b0;
            4'h1: w_cond = w_z;
            4'h2: w_cond = w_z | (w_n ^ w_v);
            4'h3: w_cond = w_n ^ w_v;
            4'h4: w_cond = w_c | w_z;
            4'h5: w_cond = w_c;
            4'h6: w_cond = w_n;
            4'h7: w_cond = w_v;
            4'h8: w_cond = 1'b1;
            4'h9: w_cond = ~w_z;
            4'hA: w_cond = ~(w_z | (w_n ^ w_v));
            4'hB: w_cond = ~(w_n ^ w_v);
            4'hC: w_cond = ~(w_c | w_z);
            4'hD: w_cond = ~w_c;
            4'hE: w_cond = ~w_n;
            4'hF: w_cond = ~w_v;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, SLOT_EXEC: begin
                if (w_accept) begin
                    if (is_branch) begin
                        // BA,a annuls its slot; a=1 on a not-taken branch does too
                        if (annul_bit && ((cond == 4'h8) || !w_cond))
                            w_next = SLOT_ANNUL;
                        else
                            w_next = SLOT_EXEC;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            SLOT_ANNUL: begin
                if (valid && !stall)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_icc   <= 4'b0000;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_next;
            // Not gated by stall: the pulse never outlives one cycle
            r_taken <= w_accept & is_branch & w_cond;
            if (w_accept && cc_we)
                r_icc <= flags_in;
        end
    end

    assign icc   = r_icc;
    assign taken = r_taken;
endmodule
